acc_drain_unit: RTL and testbench
=================================

# acc_drain_unit

Read-side counterpart of the compute core's accumulator-bank writer. After the core finishes a tile, this block walks the accumulator bank from address 0 to `cfg_rows-1`. For each row it requantizes all `ARRAY_COL` INT32 partial sums to INT8 (scale, round, optional ReLU, saturate) and streams one packed row per beat on a valid/ready output. It sits between the accumulator bank read port and the output DMA / next-layer activation buffer.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: accumulator bank address width; supports M=197.
- `COLS`, `ARRAY_COL` (16): partial sums per bank row.
- `ACC_W`, `ACC_WIDTH` (32): signed accumulator width.
- `OUT_W`, `DATA_WIDTH` (8): signed output element width.
- `RD_LATENCY`, 1: cycles from `bank_rd_en` to valid `bank_rd_data`.
- `FIFO_DEPTH`, 8: output FIFO entries, which is also the read-credit limit.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse that begins a drain; ignored while `busy`=1.
- `cfg_rows` in ADDR_WIDTH+1: rows to drain, 0..256.
- `cfg_scale` in 16: unsigned requant multiplier.
- `cfg_shift` in 5: right-shift amount, 0..31.
- `cfg_relu` in 1: clamp negative results to 0.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse at the end of a drain.
- `bank_rd_en` out 1: bank read strobe.
- `bank_rd_addr` out ADDR_WIDTH: bank read address.
- `bank_rd_data` in COLS*ACC_W: bank row; column c occupies bits [c*ACC_W +: ACC_W].
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: downstream ready.
- `m_data` out COLS*OUT_W: packed INT8 row; column c occupies bits [c*OUT_W +: OUT_W].
- `m_last` out 1: marks the beat for row `cfg_rows-1`.

## Operation
- All `cfg_*` inputs are latched on an accepted `start`. Changes while `busy` have no effect.
- FSM states:
  - IDLE (reset state): `start` with latched rows=0 goes to DONE; `start` with rows>0 goes to ISSUE.
  - ISSUE: issues reads at addresses 0,1,…,rows-1 in order. Moves to FLUSH in the cycle after the last read is issued.
  - FLUSH: waits for the last beat to be accepted (`m_valid & m_ready & m_last`), then moves to DONE.
  - DONE: `done`=1 for one cycle, then returns to IDLE.
- Credit counter `outstanding` counts reads issued but not yet popped:
  - increments on `bank_rd_en`;
  - decrements on `m_valid & m_ready`;
  - both in the same cycle leaves it unchanged.
- `bank_rd_en` = (state==ISSUE) & (`outstanding` < FIFO_DEPTH). Every issued read therefore has a guaranteed FIFO slot, so the FIFO never overflows and the bank read port is never stalled.
- Requantization, per column:
  - p = signed(acc) × unsigned(scale), computed at 49-bit signed.
  - If shift>0: r = (p + 2^(shift-1)) >>> shift (arithmetic shift, round-half-up). If shift=0: r = p.
  - If relu and r<0: r = 0.
  - Saturate to [-128, 127].
- Pipeline stages:
  1. bank read;
  2. requant register (captures `bank_rd_data` RD_LATENCY cycles after `bank_rd_en`);
  3. FIFO push;
  4. registered FIFO head drives `m_valid`/`m_data`/`m_last`.
- `m_last` travels through the pipeline with its row; it is set on the read where addr == rows-1.
- Stream rules:
  - `m_data` and `m_last` are held stable while `m_valid`=1 and `m_ready`=0.
  - `m_valid` never deasserts before acceptance.
- Reset mid-operation returns the FSM to IDLE, clears the FIFO, clears `outstanding`, and clears the address counter. No partial beat is emitted after reset.
- Reset value of every output is 0: `busy`, `done`, `bank_rd_en`, `bank_rd_addr`, `m_valid`, `m_data`, `m_last`.

## Timing
- `start` high in cycle 0, RD_LATENCY=1, `m_ready`=1:
  - `busy`=1 and `bank_rd_en`=1 with addr 0 in cycle 1;
  - requant register valid in cycle 3;
  - first `m_valid` in cycle 4.
- Steady-state throughput with `m_ready` held high is 1 row per cycle; `bank_rd_en` stays continuously high.
- `done` is asserted in the cycle after the last-beat handshake; `busy` falls in the cycle after `done`.
- `cfg_rows`=0: `done` in cycle 1, with no `bank_rd_en` and no `m_valid`.
- Back-to-back runs: a `start` in the cycle `busy` returns to 0 is accepted.

## Test plan
- Basic drain:
  - Stimulus: rows=4, scale=1, shift=0, relu=0, bank row k column c = 16k+c, `m_ready`=1.
  - Required: 4 beats in order, row k column c = 16k+c, `m_last` on beat 4 only, first `m_valid` 4 cycles after `start`, `done` 1 cycle after the last beat.
- Arithmetic, all with relu=0 unless stated:
  - acc=300, scale=1, shift=0 → 127.
  - acc=-300 → -128.
  - acc=5, scale=3, shift=1 → 8.
  - acc=-5, scale=3, shift=1 → -7.
  - acc=-50 with relu=1 → 0.
  - acc=1000, scale=3, shift=5 → 94.
- Backpressure:
  - Stimulus: rows=197, `m_ready` random at 30% low.
  - Required: 197 beats with addresses 0..196 in order, `outstanding` never >8, data stable while stalled, `m_last` only on beat 197.
- Zero rows: rows=0 → `done` in cycle 1, no reads, no beats.
- Start while busy: a second `start` issued mid-drain is ignored; exactly `cfg_rows` beats are produced using the first run's config.
- Reset mid-run:
  - Stimulus: assert `rst_n` low after 10 beats.
  - Required: all outputs 0 while in reset; after release, a new `start` with rows=3 reads from addr 0 and emits 3 correct beats.

Source files
------------

// File: rtl/acc_drain_unit.sv
// acc_drain_unit
// Drains an accumulator bank after a tile completes. Rows 0..cfg_rows-1 are
// read in order. Each INT32 partial sum is requantized to INT8 (scale, round
// half up, optional ReLU, saturate). One packed row leaves per valid/ready beat.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse; ignored while busy
//   cfg_rows/scale/shift/relu  drain configuration, latched on accepted start
//   busy, done        drain in progress / one-cycle end-of-drain pulse
//   bank_rd_en/addr   accumulator bank read strobe and address
//   bank_rd_data      bank row, RD_LATENCY cycles after the strobe
//   m_valid/m_ready/m_data/m_last  output stream, m_last on row cfg_rows-1
module acc_drain_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int COLS       = 16,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 8,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     cfg_rows,
    input  logic [15:0]             cfg_scale,
    input  logic [4:0]              cfg_shift,
    input  logic                    cfg_relu,
    output logic                    busy,
    output logic                    done,
    output logic                    bank_rd_en,
    output logic [ADDR_WIDTH-1:0]   bank_rd_addr,
    input  logic [COLS*ACC_W-1:0]   bank_rd_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [COLS*OUT_W-1:0]   m_data,
    output logic                    m_last
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PROD_W = ACC_W + 17;

    localparam logic [CNT_W-1:0]         DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]         PTR_MAX_C = PTR_W'(FIFO_DEPTH - 1);
    localparam logic signed [PROD_W-1:0] ONE_C     = {{(PROD_W-1){1'b0}}, 1'b1};
    localparam logic signed [PROD_W-1:0] SAT_MAX_C = PROD_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [PROD_W-1:0] SAT_MIN_C = -SAT_MAX_C - ONE_C;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     rows_q;
    logic [15:0]             scale_q;
    logic [4:0]              shift_q;
    logic                    relu_q;
    logic [CNT_W-1:0]        outstanding_q;
    logic [RD_LATENCY-1:0]   rd_vld_q;
    logic [RD_LATENCY-1:0]   rd_last_q;
    logic                    q_vld_q;
    logic                    q_last_q;
    logic [COLS*OUT_W-1:0]   q_data_q;
    logic [COLS*OUT_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last_q;
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        fifo_cnt_q;

    logic                    rd_en_s;
    logic                    rd_last_s;
    logic                    pop_s;
    logic [COLS*OUT_W-1:0]   requant_row_s;

    // Signed acc times unsigned scale, round half up, optional ReLU, saturate.
    function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] acc,
                                                 input logic [15:0]      scale,
                                                 input logic [4:0]       shift,
                                                 input logic             relu);
        logic signed [PROD_W-1:0] p;
        logic signed [PROD_W-1:0] rnd;
        logic signed [PROD_W-1:0] r;
        p = $signed({{17{acc[ACC_W-1]}}, acc}) * $signed({{(ACC_W+1){1'b0}}, scale});
        if (shift == 5'd0) begin
            rnd = '0;
        end else begin
            rnd = ONE_C <<< (shift - 5'd1);
        end
        r = (p + rnd) >>> shift;
        if (relu && r[PROD_W-1]) begin
            r = '0;
        end else begin
            r = r;
        end
        if (r > SAT_MAX_C) begin
            return SAT_MAX_C[OUT_W-1:0];
        end else if (r < SAT_MIN_C) begin
            return SAT_MIN_C[OUT_W-1:0];
        end else begin
            return r[OUT_W-1:0];
        end
    endfunction

    // A read is only issued when a FIFO slot is guaranteed for its result.
    assign rd_en_s   = (state_q == S_ISSUE) && (outstanding_q < DEPTH_C);
    assign rd_last_s = ({1'b0, addr_q} == (rows_q - {{ADDR_WIDTH{1'b0}}, 1'b1}));
    assign pop_s     = m_valid && m_ready;

    // Requantize every column of the row currently on the bank read port.
    always_comb begin
        requant_row_s = '0;
        for (int c = 0; c < COLS; c++) begin
            requant_row_s[c*OUT_W +: OUT_W] =
                requant(bank_rd_data[c*ACC_W +: ACC_W], scale_q, shift_q, relu_q);
        end
    end

    // Drain sequencer: config latch, read address walk, busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            rows_q  <= '0;
            scale_q <= 16'd0;
            shift_q <= 5'd0;
            relu_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rows_q  <= cfg_rows;
                        scale_q <= cfg_scale;
                        shift_q <= cfg_shift;
                        relu_q  <= cfg_relu;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        if (cfg_rows == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (rd_en_s && rd_last_s) begin
                        state_q <= S_FLUSH;
                        addr_q  <= '0;
                    end else if (rd_en_s) begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (pop_s && m_last) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read credits: rows issued to the bank and not yet popped downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
        end else begin
            case ({rd_en_s, pop_s})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Track read latency, then capture the requantized row with its last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q  <= '0;
            rd_last_q <= '0;
            q_vld_q   <= 1'b0;
            q_last_q  <= 1'b0;
            q_data_q  <= '0;
        end else begin
            rd_vld_q[0]  <= rd_en_s;
            rd_last_q[0] <= rd_en_s && rd_last_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_q[i]  <= rd_vld_q[i-1];
                rd_last_q[i] <= rd_last_q[i-1];
            end
            q_vld_q <= rd_vld_q[RD_LATENCY-1];
            if (rd_vld_q[RD_LATENCY-1]) begin
                q_data_q <= requant_row_s;
                q_last_q <= rd_last_q[RD_LATENCY-1];
            end
        end
    end

    // Output FIFO; credits guarantee a push never meets a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            if (q_vld_q) begin
                fifo_data_q[wr_ptr_q] <= q_data_q;
                fifo_last_q[wr_ptr_q] <= q_last_q;
                wr_ptr_q <= (wr_ptr_q == PTR_MAX_C) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_q <= (rd_ptr_q == PTR_MAX_C) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({q_vld_q, pop_s})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign bank_rd_en   = rd_en_s;
    assign bank_rd_addr = addr_q;
    assign m_valid      = (fifo_cnt_q != '0);
    assign m_data       = fifo_data_q[rd_ptr_q];
    assign m_last       = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_acc_drain_unit.sv
// Directed bench for acc_drain_unit: a bank model answers reads one cycle
// later, a negedge monitor records reads, beats and done, and every check
// goes through check_eq.
module tb_acc_drain_unit;

    localparam int COLS  = 16;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int AW    = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [AW:0]           cfg_rows;
    logic [15:0]           cfg_scale;
    logic [4:0]            cfg_shift;
    logic                  cfg_relu;
    logic                  busy, done, bank_rd_en;
    logic [AW-1:0]         bank_rd_addr;
    logic [COLS*ACC_W-1:0] bank_rd_data;
    logic                  m_valid, m_ready, m_last;
    logic [COLS*OUT_W-1:0] m_data;

    acc_drain_unit #(.ADDR_WIDTH(AW), .COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W),
                     .RD_LATENCY(1), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows),
        .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .busy(busy), .done(done), .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr),
        .bank_rd_data(bank_rd_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [COLS*ACC_W-1:0] bank_mem [0:255];
    always @(posedge clk) if (bank_rd_en) bank_rd_data <= bank_mem[bank_rd_addr];

    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) m_ready = ($urandom_range(0, 99) >= 30);
        else               m_ready = 1'b1;
    end

    // Monitor state
    logic                  mon_clr = 1'b0;
    int                    rd_cnt, addr_err, out_m, max_out, stab_err;
    int                    first_rd_cyc, first_valid_cyc, last_beat_cyc, done_cyc, done_cnt;
    logic [AW-1:0]         first_rd_addr;
    logic [COLS*OUT_W-1:0] beat_q [$];
    bit                    last_q [$];
    bit                    stall_prev;
    logic [COLS*OUT_W-1:0] prev_data;
    logic                  prev_last;

    always @(negedge clk) begin
        if (mon_clr || !rst_n) begin
            rd_cnt = 0; addr_err = 0; out_m = 0; max_out = 0; stab_err = 0;
            first_rd_cyc = -1; first_valid_cyc = -1; last_beat_cyc = -1;
            done_cyc = -1; done_cnt = 0; first_rd_addr = '0;
            beat_q.delete(); last_q.delete(); stall_prev = 1'b0;
        end else begin
            if (bank_rd_en) begin
                if (rd_cnt == 0) begin
                    first_rd_cyc  = cyc;
                    first_rd_addr = bank_rd_addr;
                end
                if (int'(bank_rd_addr) != rd_cnt) addr_err++;
                rd_cnt++;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                beat_q.push_back(m_data);
                last_q.push_back(m_last);
                last_beat_cyc = cyc;
            end
            out_m = out_m + (bank_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            if (out_m > max_out) max_out = out_m;
            if (stall_prev && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_err++;
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (done) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int start_cyc;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        mon_clr = 1'b1;
        tick(1);
        mon_clr = 1'b0;
    endtask

    task automatic do_start(input int rows, input int scale, input int shift, input bit relu);
        cfg_rows  = 9'(rows);
        cfg_scale = 16'(scale);
        cfg_shift = 5'(shift);
        cfg_relu  = relu;
        start     = 1'b1;
        start_cyc = cyc;
        tick(1);
        start     = 1'b0;
        cfg_rows  = 9'd7;
        cfg_scale = 16'd9;
        cfg_shift = 5'd3;
        cfg_relu  = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget, input int tail, input int want);
        int n = 0;
        while (done_cnt < want && n < budget) begin
            tick(1);
            n++;
        end
        if (done_cnt < want) check_eq({tag, "_timeout"}, 128'd0, 128'd1);
        tick(tail);
    endtask

    // mode 0: 16k+c, mode 1: ((k+c) mod 256) - 128, mode 2: every element = aval
    function automatic int elem(input int mode, input int k, input int c, input int aval);
        if (mode == 0)      return 16 * k + c;
        else if (mode == 1) return ((k + c) % 256) - 128;
        else                return aval;
    endfunction

    task automatic fill_bank(input int mode, input int aval);
        for (int k = 0; k < 256; k++)
            for (int c = 0; c < COLS; c++)
                bank_mem[k][c*ACC_W +: ACC_W] = 32'(elem(mode, k, c, aval));
    endtask

    // Expected row when the values already fit in INT8 and scale=1, shift=0.
    function automatic logic [127:0] exp_row(input int mode, input int k);
        logic [127:0] r = '0;
        for (int c = 0; c < COLS; c++) r[c*OUT_W +: OUT_W] = 8'(elem(mode, k, c, 0));
        return r;
    endfunction

    function automatic logic [127:0] get_beat(input int k);
        if (k < beat_q.size()) return beat_q[k];
        else return {128{1'bx}};
    endfunction

    function automatic int lasts_mask;
        int m = 0;
        for (int i = 0; i < last_q.size() && i < 31; i++) if (last_q[i]) m |= (1 << i);
        return m;
    endfunction

    int a_acc   [6] = '{300, -300, 5, -5, -50, 1000};
    int a_scale [6] = '{1, 1, 3, 3, 1, 3};
    int a_shift [6] = '{0, 0, 1, 1, 0, 5};
    int a_relu  [6] = '{0, 0, 0, 0, 1, 0};
    int a_exp   [6] = '{127, -128, 8, -7, 0, 94};

    initial begin
        int bad, nl, n;
        logic [7:0] e8;
        rst_n = 1'b0; start = 1'b0;
        cfg_rows = '0; cfg_scale = '0; cfg_shift = '0; cfg_relu = 1'b0;
        fill_bank(0, 0);
        tick(3);
        check_eq("reset_ctl", {busy, done, bank_rd_en, m_valid, m_last}, 5'b0);
        check_eq("reset_addr", bank_rd_addr, 8'd0);
        check_eq("reset_data", m_data, 128'd0);
        rst_n = 1'b1;
        tick(2);

        // Basic drain and timing
        clear_mon;
        do_start(4, 1, 0, 1'b0);
        wait_done("basic", 50, 2, 1);
        check_eq("basic_beats", beat_q.size(), 4);
        for (int k = 0; k < 4; k++) check_eq($sformatf("basic_row%0d", k), get_beat(k), exp_row(0, k));
        check_eq("basic_last", lasts_mask(), 4'b1000);
        check_eq("basic_first_rd", first_rd_cyc - start_cyc, 1);
        check_eq("basic_first_valid", first_valid_cyc - start_cyc, 4);
        check_eq("basic_done_lat", done_cyc - last_beat_cyc, 1);
        check_eq("basic_busy_low", busy, 1'b0);

        // Requantization arithmetic
        for (int i = 0; i < 6; i++) begin
            fill_bank(2, a_acc[i]);
            clear_mon;
            do_start(1, a_scale[i], a_shift[i], a_relu[i][0]);
            wait_done($sformatf("arith%0d", i), 50, 2, 1);
            e8 = 8'(a_exp[i]);
            check_eq($sformatf("arith%0d_acc%0d", i, a_acc[i]), get_beat(0), {COLS{e8}});
        end

        // Backpressure over 197 rows
        fill_bank(1, 0);
        rdy_mode = 1;
        clear_mon;
        do_start(197, 1, 0, 1'b0);
        wait_done("bp", 4000, 2, 1);
        rdy_mode = 0;
        check_eq("bp_beats", beat_q.size(), 197);
        bad = 0;
        for (int k = 0; k < 197; k++) if (get_beat(k) !== exp_row(1, k)) bad++;
        check_eq("bp_data_bad", bad, 0);
        check_eq("bp_reads", rd_cnt, 197);
        check_eq("bp_addr_order_err", addr_err, 0);
        check_eq("bp_credit_over8", max_out > 8, 1'b0);
        check_eq("bp_stall_unstable", stab_err, 0);
        nl = 0;
        foreach (last_q[i]) nl += int'(last_q[i]);
        check_eq("bp_last_count", nl, 1);
        check_eq("bp_last_on_final", (last_q.size() == 197) ? last_q[196] : 1'b0, 1'b1);

        // Zero rows
        clear_mon;
        do_start(0, 1, 0, 1'b0);
        wait_done("zero", 20, 4, 1);
        check_eq("zero_done_cyc", done_cyc - start_cyc, 1);
        check_eq("zero_reads", rd_cnt, 0);
        check_eq("zero_beats", beat_q.size(), 0);

        // Start while busy is ignored
        fill_bank(0, 0);
        clear_mon;
        do_start(5, 1, 0, 1'b0);
        tick(2);
        do_start(2, 4, 0, 1'b1);
        wait_done("busy_start", 60, 10, 1);
        check_eq("busy_start_beats", beat_q.size(), 5);
        bad = 0;
        for (int k = 0; k < 5; k++) if (get_beat(k) !== exp_row(0, k)) bad++;
        check_eq("busy_start_data_bad", bad, 0);
        check_eq("busy_start_done_cnt", done_cnt, 1);

        // Back-to-back: start in the cycle busy returns low
        clear_mon;
        do_start(2, 1, 0, 1'b0);
        wait_done("b2b_first", 50, 0, 1);
        check_eq("b2b_busy_low", busy, 1'b0);
        do_start(3, 1, 0, 1'b0);
        wait_done("b2b_second", 50, 2, 2);
        check_eq("b2b_beats", beat_q.size(), 5);
        check_eq("b2b_row2_of_2nd", get_beat(4), exp_row(0, 2));

        // Reset in the middle of a long drain
        clear_mon;
        do_start(197, 1, 0, 1'b0);
        n = 0;
        while (beat_q.size() < 10 && n < 200) begin
            tick(1);
            n++;
        end
        check_eq("rst_mid_reached10", beat_q.size() >= 10, 1'b1);
        rst_n = 1'b0;
        #2;
        check_eq("rst_mid_ctl", {busy, done, bank_rd_en, m_valid, m_last}, 5'b0);
        check_eq("rst_mid_data", {bank_rd_addr, m_data}, 136'd0);
        tick(2);
        check_eq("rst_mid_ctl_hold", {busy, done, bank_rd_en, m_valid, m_last}, 5'b0);
        rst_n = 1'b1;
        tick(1);
        clear_mon;
        do_start(3, 1, 0, 1'b0);
        wait_done("rst_after", 50, 2, 1);
        check_eq("rst_after_first_addr", first_rd_addr, 8'd0);
        check_eq("rst_after_reads", rd_cnt, 3);
        check_eq("rst_after_beats", beat_q.size(), 3);
        bad = 0;
        for (int k = 0; k < 3; k++) if (get_beat(k) !== exp_row(0, k)) bad++;
        check_eq("rst_after_data_bad", bad, 0);
        check_eq("rst_after_last", lasts_mask(), 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
